haraka_perm_sched: RTL and testbench
====================================

Name: haraka_perm_sched

Overview:
- Round scheduler and controller for the Haraka-512 permutation datapath.
- Datapath per round: two registered quad-AES stages, then the 512-bit mix.
- Accepts one 512-bit state over a valid/ready handshake and drives the round datapath for NUM_ROUNDS rounds.
- Selects the round-constant group for each round, captures and feeds back intermediate state, applies optional feed-forward, and returns the result over a valid/ready handshake.

Parameters:
- W, 512, state width in bits.
- NUM_ROUNDS, 5, Haraka rounds per permutation; legal range 1..8.
- ROUND_LAT, 2, cycles from core_in change to valid core_out (one per registered AES stage); must be ≥1.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- in_valid  input  1  request: in_data/in_ffwd valid.
- in_ready  output  1  scheduler can accept a request.
- in_data  input  W  permutation input state x.
- in_ffwd  input  1  1 = output P(x) xor x; 0 = output P(x).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  W  result.
- core_in  output  W  state driven into round datapath.
- core_rc_idx  output  3  round-constant group index (selects the 8 x 128-bit constants for this round).
- core_out  input  W  round datapath output (after mix).
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, RUN, DONE. Internal regs:
  - x_reg[W]: captured input.
  - st_reg[W]: feedback state.
  - ffwd_reg.
  - round[2:0].
  - lat_cnt (width clog2(ROUND_LAT), min 1).
- Reset (async): state=IDLE; round=0, lat_cnt=0; x_reg, st_reg, out_data = 0; out_valid=0; ffwd_reg=0; core_rc_idx=0. in_ready reads 1 once reset deasserts; it is 0 while reset is high.
- in_ready = (state==IDLE) && !reset. out_valid = (state==DONE). busy = (state!=IDLE).
- IDLE: on in_valid&&in_ready:
  - x_reg<=in_data, ffwd_reg<=in_ffwd.
  - round<=0, lat_cnt<=0 → RUN.
  - in_valid without in_ready has no effect.
- RUN:
  - core_in = (round==0) ? x_reg : st_reg. core_rc_idx = round. Both are held stable for ROUND_LAT cycles.
  - lat_cnt increments each cycle.
  - When lat_cnt==ROUND_LAT-1: sample core_out and set lat_cnt<=0.
    - If round<NUM_ROUNDS-1: st_reg<=core_out, round<=round+1.
    - Else: out_data <= core_out ^ (ffwd_reg ? x_reg : 0) → DONE.
  - core_out is ignored on all other cycles.
- DONE:
  - out_valid=1; out_data held stable until out_ready.
  - On out_valid&&out_ready → IDLE, round<=0.
  - in_ready=0 throughout RUN and DONE; no overlap between permutations.
- core_in in IDLE/DONE = x_reg; core_rc_idx = 0. The datapath output is don't-care there.
- Latency: accept edge E0 → out_valid high after edge E0+NUM_ROUNDS*ROUND_LAT. Default: 10 cycles.
- Minimum request period: NUM_ROUNDS*ROUND_LAT+2 cycles (12 at defaults).
- Reset mid-RUN or mid-DONE aborts immediately:
  - out_valid drops asynchronously.
  - Partial state is discarded.
  - No result is emitted for the aborted request.
- Arithmetic: round compare uses 3 bits; NUM_ROUNDS-1 must fit in 3 bits. Feed-forward XOR is bitwise over full W; no truncation in this block.

Test Plan:
- Single permutation, in_ffwd=0, ROUND_LAT=2, model core: core_out = rotl(core_in,1) ^ {64{core_rc_idx,5'b0}} delayed 2 cycles.
  - Expect core_rc_idx sequence 0,0,1,1,2,2,3,3,4,4.
  - out_valid exactly 10 cycles after accept.
  - out_data equals the 5-round model result.
- Same input with in_ffwd=1 → out_data = previous result xor in_data; all-ones input gives the bitwise complement of the ffwd=0 result.
- Backpressure:
  - Hold out_ready=0 for 6 cycles with in_valid=1 throughout → out_data constant, out_valid=1, in_ready=0, no second capture.
  - out_ready=1 → IDLE next cycle; the pending request is then accepted; second result is correct.
- Back-to-back requests with out_ready=1 continuously → accepts spaced exactly 12 cycles apart; results match model in order.
- Assert reset during RUN at round=2 → out_valid=0, busy=0, in_ready=1 after release; next request gives the correct fresh result with no state leakage from the aborted run.
- Parameter variant ROUND_LAT=1, NUM_ROUNDS=8 → core_rc_idx 0..7, one cycle each; out_valid 8 cycles after accept.

Source files
------------

// File: rtl/haraka_perm_sched.sv
// haraka_perm_sched
// -----------------------------------------------------------------------------
// Round scheduler for the Haraka-512 permutation. It accepts one W-bit state,
// steps an external round datapath (two registered quad-AES stages + mix)
// through NUM_ROUNDS rounds, and returns the permuted state. With in_ffwd set,
// it returns P(x) xor x instead of P(x).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds valid and its data stable until that edge.
// The scheduler holds out_valid/out_data stable until the consumer takes them.
// It takes only one request at a time, so in_ready is low from accept until
// the result has been taken.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   in_valid/in_ready      request handshake; in_data = x, in_ffwd = feed-forward
//   out_valid/out_ready    result handshake; out_data = result
//   core_in, core_rc_idx   state and round-constant group driven to the datapath
//   core_out               datapath output, sampled once per round
//   busy                   high whenever a permutation is in flight or pending
//   dbg_state              current FSM state (0 idle, 1 run, 2 done)
// -----------------------------------------------------------------------------
module haraka_perm_sched #(
    parameter int W          = 512,
    parameter int NUM_ROUNDS = 5,
    parameter int ROUND_LAT  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_ffwd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [W-1:0] core_in,
    output logic [2:0]   core_rc_idx,
    input  logic [W-1:0] core_out,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam int               LAT_W      = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
    localparam logic [2:0]       LAST_ROUND = 3'(NUM_ROUNDS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(ROUND_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [W-1:0]     x_reg;
    logic [W-1:0]     st_reg;
    logic             ffwd_reg;
    logic [2:0]       round;
    logic [LAT_W-1:0] lat_cnt;

    logic accept;
    logic sample;
    logic last_round;

    // Control decode, next state and datapath-facing outputs.
    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        sample      = 1'b0;
        last_round  = (round == LAST_ROUND);
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        core_in     = x_reg;
        core_rc_idx = 3'd0;

        case (state)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = !reset;
                accept   = in_valid && !reset;
                if (accept) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                // Round 0 works on the captured input; later rounds on feedback.
                core_in     = (round == 3'd0) ? x_reg : st_reg;
                core_rc_idx = round;
                // core_out is trusted only on the last cycle of each round.
                sample      = (lat_cnt == LAT_LAST);
                if (sample && last_round) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg    <= '0;
            st_reg   <= '0;
            ffwd_reg <= 1'b0;
            round    <= 3'd0;
            lat_cnt  <= '0;
            out_data <= '0;
        end else begin
            if (accept) begin
                x_reg    <= in_data;
                ffwd_reg <= in_ffwd;
                round    <= 3'd0;
                lat_cnt  <= '0;
            end

            if (state == S_RUN) begin
                if (sample) begin
                    lat_cnt <= '0;
                    if (!last_round) begin
                        st_reg <= core_out;
                        round  <= round + 3'd1;
                    end else begin
                        out_data <= core_out ^ (ffwd_reg ? x_reg : '0);
                    end
                end else begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                end
            end

            if ((state == S_DONE) && out_ready) begin
                round <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_haraka_perm_sched.sv
// Testbench for haraka_perm_sched: a default instance (5 rounds, 2-cycle
// rounds) and a variant instance (8 rounds, 1-cycle rounds), each attached to
// a model round core computing rotl(core_in,1) ^ {64{core_rc_idx,5'b0}}.
module tb_haraka_perm_sched;

    localparam int W = 512;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic         in_valid_a, in_ready_a, in_ffwd_a, out_valid_a, out_ready_a, busy_a;
    logic [W-1:0] in_data_a, out_data_a, core_in_a, core_out_a;
    logic [2:0]   core_rc_a;
    logic [1:0]   dbg_a;

    haraka_perm_sched #(.W(W), .NUM_ROUNDS(5), .ROUND_LAT(2)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_ffwd(in_ffwd_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .core_in(core_in_a), .core_rc_idx(core_rc_a), .core_out(core_out_a),
        .busy(busy_a), .dbg_state(dbg_a)
    );

    // ---------------- variant instance ----------------
    logic         in_valid_b, in_ready_b, in_ffwd_b, out_valid_b, out_ready_b, busy_b;
    logic [W-1:0] in_data_b, out_data_b, core_in_b, core_out_b;
    logic [2:0]   core_rc_b;
    logic [1:0]   dbg_b;

    haraka_perm_sched #(.W(W), .NUM_ROUNDS(8), .ROUND_LAT(1)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_ffwd(in_ffwd_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .core_in(core_in_b), .core_rc_idx(core_rc_b), .core_out(core_out_b),
        .busy(busy_b), .dbg_state(dbg_b)
    );

    // ---------------- model round cores ----------------
    function automatic logic [W-1:0] core_f(input logic [W-1:0] s, input logic [2:0] rc);
        logic [7:0] rc_byte;
        rc_byte = {rc, 5'b0};
        return {s[W-2:0], s[W-1]} ^ {64{rc_byte}};
    endfunction

    function automatic logic [W-1:0] model_perm(input logic [W-1:0] x, input int nr, input logic ffwd);
        logic [W-1:0] s;
        s = x;
        for (int r = 0; r < nr; r++) s = core_f(s, 3'(r));
        return ffwd ? (s ^ x) : s;
    endfunction

    // Two-cycle core: result of a core_in that was stable over the round
    // appears on the last cycle of the round.
    always_ff @(posedge clk) core_out_a <= core_f(core_in_a, core_rc_a);
    // One-cycle core.
    assign core_out_b = core_f(core_in_b, core_rc_b);

    // ---------------- bookkeeping ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] rc_log[0:63];
    int         rc_n;
    int         lat_cycles;
    logic [W-1:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise in_valid and return just after the accept edge.
    task automatic send_a(input logic [W-1:0] x, input logic f);
        int guard;
        guard = 0;
        in_data_a  = x;
        in_ffwd_a  = f;
        in_valid_a = 1'b1;
        while (!in_ready_a && guard < 50) begin
            step();
            guard++;
        end
        step();
        in_valid_a = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid, logging core_rc_idx.
    task automatic wait_out_a();
        lat_cycles = 0;
        rc_n = 0;
        while (!out_valid_a && lat_cycles < 100) begin
            if (rc_n < 64) rc_log[rc_n] = core_rc_a;
            rc_n++;
            step();
            lat_cycles++;
        end
    endtask

    task automatic pop_a();
        out_ready_a = 1'b1;
        step();
        out_ready_a = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        in_valid_a = 0; in_ffwd_a = 0; in_data_a = '0; out_ready_a = 0;
        in_valid_b = 0; in_ffwd_b = 0; in_data_b = '0; out_ready_b = 0;
        step();
        step();
        n_checks++;
        if (in_ready_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready_a);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready_a !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready_high: got %b expected 1", in_ready_a);
        end
        n_checks++;
        if ({out_valid_a, busy_a, core_rc_a, dbg_a} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got valid=%b busy=%b rc=%0d st=%0d expected all 0",
                               out_valid_a, busy_a, core_rc_a, dbg_a);
        end
        n_checks++;
        if (out_data_a !== '0) begin
            n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data_a);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] xa;
        logic [2:0]   exp_rc;
        // Zero input: hand-derived result is 0x40 in every byte.
        send_a('0, 1'b0);
        wait_out_a();
        n_checks++;
        if (lat_cycles != 10) begin
            n_fail++; $display("FAIL single_latency: got %0d expected 10", lat_cycles);
        end
        for (int i = 0; i < 10; i++) begin
            exp_rc = 3'(i / 2);
            n_checks++;
            if (rc_log[i] !== exp_rc) begin
                n_fail++; $display("FAIL single_rc_idx[%0d]: got %0d expected %0d", i, rc_log[i], exp_rc);
            end
        end
        n_checks++;
        if (out_data_a !== {64{8'h40}}) begin
            n_fail++; $display("FAIL single_zero_data: got %h expected %h", out_data_a, {64{8'h40}});
        end
        pop_a();

        xa = {16{32'h0123_4567}} ^ {8{64'hF0E1_D2C3_B4A5_9687}};
        send_a(xa, 1'b0);
        wait_out_a();
        n_checks++;
        if (out_data_a !== model_perm(xa, 5, 1'b0)) begin
            n_fail++; $display("FAIL single_pattern_data: got %h expected %h", out_data_a, model_perm(xa, 5, 1'b0));
        end
        pop_a();
    endtask

    task automatic test_ffwd();
        logic [W-1:0] xa;
        logic [W-1:0] ones;
        xa   = {16{32'h0123_4567}} ^ {8{64'hF0E1_D2C3_B4A5_9687}};
        ones = '1;
        send_a(xa, 1'b1);
        wait_out_a();
        n_checks++;
        if (out_data_a !== (model_perm(xa, 5, 1'b0) ^ xa)) begin
            n_fail++; $display("FAIL ffwd_pattern: got %h expected %h", out_data_a, model_perm(xa, 5, 1'b0) ^ xa);
        end
        pop_a();

        send_a(ones, 1'b0);
        wait_out_a();
        n_checks++;
        if (out_data_a !== model_perm(ones, 5, 1'b0)) begin
            n_fail++; $display("FAIL ffwd_ones_plain: got %h expected %h", out_data_a, model_perm(ones, 5, 1'b0));
        end
        pop_a();

        send_a(ones, 1'b1);
        wait_out_a();
        n_checks++;
        if (out_data_a !== ~model_perm(ones, 5, 1'b0)) begin
            n_fail++; $display("FAIL ffwd_ones_complement: got %h expected %h", out_data_a, ~model_perm(ones, 5, 1'b0));
        end
        pop_a();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] xb, xc;
        xb = {32{16'hA5C3}};
        xc = {4{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF}};
        send_a(xb, 1'b0);
        // A second request waits while the first result is stalled.
        in_data_a = xc; in_ffwd_a = 1'b0; in_valid_a = 1'b1; out_ready_a = 1'b0;
        wait_out_a();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({out_valid_a, in_ready_a, busy_a} !== 3'b101) begin
                n_fail++; $display("FAIL bp_ctrl[%0d]: got valid=%b ready=%b busy=%b expected 1 0 1",
                                   i, out_valid_a, in_ready_a, busy_a);
            end
            n_checks++;
            if (out_data_a !== model_perm(xb, 5, 1'b0)) begin
                n_fail++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", i, out_data_a, model_perm(xb, 5, 1'b0));
            end
            step();
        end
        out_ready_a = 1'b1;
        step();
        out_ready_a = 1'b0;
        n_checks++;
        if ({in_ready_a, out_valid_a} !== 2'b10) begin
            n_fail++; $display("FAIL bp_release_idle: got ready=%b valid=%b expected 1 0", in_ready_a, out_valid_a);
        end
        step();
        in_valid_a = 1'b0;
        wait_out_a();
        n_checks++;
        if (lat_cycles != 10) begin
            n_fail++; $display("FAIL bp_second_latency: got %0d expected 10", lat_cycles);
        end
        n_checks++;
        if (out_data_a !== model_perm(xc, 5, 1'b0)) begin
            n_fail++; $display("FAIL bp_second_data: got %h expected %h", out_data_a, model_perm(xc, 5, 1'b0));
        end
        pop_a();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xs[4];
        int  accepts, results, cyc, last_acc;
        logic acc, outv;
        logic [W-1:0] exp_v;
        xs[0] = {64{8'h5A}};
        xs[1] = {16{32'hCAFE_F00D}};
        xs[2] = {8{64'h1}};
        xs[3] = {2{256'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0001}};
        accepts = 0; results = 0; cyc = 0; last_acc = -1;
        in_data_a = xs[0]; in_ffwd_a = 1'b0; in_valid_a = 1'b1; out_ready_a = 1'b1;
        while (results < 4 && cyc < 200) begin
            acc  = in_valid_a && in_ready_a;
            outv = out_valid_a && out_ready_a;
            if (outv) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data_a;
                n_checks++;
                if (out_data_a !== exp_v) begin
                    n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", results, out_data_a, exp_v);
                end
                results++;
            end
            if (acc) begin
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != 12) begin
                        n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 12", accepts, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                exp_q.push_back(model_perm(in_data_a, 5, in_ffwd_a));
                accepts++;
            end
            step();
            cyc++;
            if (acc) begin
                if (accepts < 4) begin
                    in_data_a = xs[accepts];
                    in_ffwd_a = accepts[0];
                end else begin
                    in_valid_a = 1'b0;
                end
            end
        end
        out_ready_a = 1'b0;
        in_valid_a  = 1'b0;
        n_checks++;
        if (results != 4) begin
            n_fail++; $display("FAIL b2b_result_count: got %0d expected 4", results);
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] xd, xe;
        int guard;
        xd = {16{32'h7777_1234}};
        xe = {64{8'h3C}} ^ {8{64'h0000_0000_FFFF_0000}};
        send_a(xd, 1'b1);
        guard = 0;
        while (core_rc_a != 3'd2 && guard < 20) begin
            step();
            guard++;
        end
        n_checks++;
        if (core_rc_a !== 3'd2) begin
            n_fail++; $display("FAIL abort_reach_round2: got %0d expected 2", core_rc_a);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid_a, busy_a, in_ready_a, dbg_a} !== 5'b0) begin
            n_fail++; $display("FAIL abort_during_reset: got valid=%b busy=%b ready=%b st=%0d expected all 0",
                               out_valid_a, busy_a, in_ready_a, dbg_a);
        end
        step();
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({in_ready_a, out_valid_a, busy_a} !== 3'b100) begin
            n_fail++; $display("FAIL abort_after_release: got ready=%b valid=%b busy=%b expected 1 0 0",
                               in_ready_a, out_valid_a, busy_a);
        end
        send_a(xe, 1'b1);
        wait_out_a();
        n_checks++;
        if (lat_cycles != 10) begin
            n_fail++; $display("FAIL abort_fresh_latency: got %0d expected 10", lat_cycles);
        end
        n_checks++;
        if (out_data_a !== model_perm(xe, 5, 1'b1)) begin
            n_fail++; $display("FAIL abort_fresh_data: got %h expected %h", out_data_a, model_perm(xe, 5, 1'b1));
        end
        pop_a();
    endtask

    task automatic test_variant();
        logic [W-1:0] xv[2];
        logic [W-1:0] exp_v;
        xv[0] = '0;
        xv[1] = {16{32'h0123_4567}} ^ {8{64'hF0E1_D2C3_B4A5_9687}};
        for (int k = 0; k < 2; k++) begin
            in_data_b = xv[k]; in_ffwd_b = k[0]; in_valid_b = 1'b1;
            n_checks++;
            if (in_ready_b !== 1'b1) begin
                n_fail++; $display("FAIL var_in_ready[%0d]: got %b expected 1", k, in_ready_b);
            end
            step();
            in_valid_b = 1'b0;
            lat_cycles = 0;
            rc_n = 0;
            while (!out_valid_b && lat_cycles < 100) begin
                if (rc_n < 64) rc_log[rc_n] = core_rc_b;
                rc_n++;
                step();
                lat_cycles++;
            end
            n_checks++;
            if (lat_cycles != 8) begin
                n_fail++; $display("FAIL var_latency[%0d]: got %0d expected 8", k, lat_cycles);
            end
            if (k == 0) begin
                for (int i = 0; i < 8; i++) begin
                    n_checks++;
                    if (rc_log[i] !== 3'(i)) begin
                        n_fail++; $display("FAIL var_rc_idx[%0d]: got %0d expected %0d", i, rc_log[i], i);
                    end
                end
            end
            // Zero input through 8 rounds is hand-derived as 0xE1 per byte.
            exp_v = (k == 0) ? {64{8'hE1}} : model_perm(xv[1], 8, 1'b1);
            n_checks++;
            if (out_data_b !== exp_v) begin
                n_fail++; $display("FAIL var_data[%0d]: got %h expected %h", k, out_data_b, exp_v);
            end
            out_ready_b = 1'b1;
            step();
            out_ready_b = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ffwd();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_variant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
